entropy_conditioner: RTL

Conditioning stage between the raw ring-oscillator entropy source and the storage manager.
- Synchronises the asynchronous raw bit and runs two online health tests on it: repetition count and adaptive proportion.
- Removes bias with a von Neumann extractor.
- Emits one conditioned bit plus a one-cycle valid strobe per accepted pair. This stream feeds the storage manager's random-bit input.
- Any health failure gates output off until software clears it.

---
 rtl/entropy_pkg.sv | 29 ++
 rtl/health_monitor.sv | 130 +++++++++++++
 rtl/entropy_conditioner.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/entropy_pkg.sv
// Shared definitions for the entropy conditioner: pair-state encoding,
// default health-test cutoffs and counter-width helpers.
package entropy_pkg;

  // Von Neumann pair tracker: nothing stored, or first bit of a pair stored
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pair_state_e;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int REP_CUTOFF_DEF      = 32;
  localparam int APT_WINDOW_DEF      = 512;
  localparam int APT_CUTOFF_DEF      = 410;
  localparam int STARTUP_SAMPLES_DEF = 1024;

  // Bits needed to hold the values 0..max_value (never less than one bit)
  function automatic int cnt_width(input int max_value);
    int w;
    w = $clog2(max_value + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/health_monitor.sv
// Online health tests on the synchronised raw entropy bit: repetition count
// and adaptive proportion. Both failure flags are sticky until clear_fail.
// A failure detected in the same cycle as clear_fail keeps its flag set.
module health_monitor import entropy_pkg::*; #(
  parameter int REP_CUTOFF = REP_CUTOFF_DEF,
  parameter int APT_WINDOW = APT_WINDOW_DEF,
  parameter int APT_CUTOFF = APT_CUTOFF_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_bit,
  input  logic sample_en,
  input  logic clear_fail,
  output logic rep_fail,
  output logic apt_fail
);

  localparam int REP_W   = cnt_width(REP_CUTOFF);
  localparam int IDX_W   = $clog2(APT_WINDOW);
  localparam int MATCH_W = cnt_width(APT_WINDOW);

  localparam logic [REP_W-1:0]   REP_ZERO  = REP_W'(0);
  localparam logic [REP_W-1:0]   REP_ONE   = REP_W'(1);
  localparam logic [REP_W-1:0]   REP_MAX   = REP_W'(REP_CUTOFF);
  localparam logic [IDX_W-1:0]   IDX_ZERO  = IDX_W'(0);
  localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
  localparam logic [MATCH_W-1:0] MATCH_ZERO = MATCH_W'(0);
  localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(APT_CUTOFF);

  logic [REP_W-1:0]   rep_cnt_r;
  logic               prev_bit_r;
  logic [IDX_W-1:0]   win_idx_r;
  logic               ref_bit_r;
  logic [MATCH_W-1:0] match_cnt_r;
  logic               rep_fail_r;
  logic               apt_fail_r;

  logic [REP_W-1:0]   rep_cnt_nxt_s;
  logic [MATCH_W-1:0] match_cnt_nxt_s;
  logic               ref_bit_nxt_s;
  logic               rep_hit_s;
  logic               apt_hit_s;

  // Repetition count: a zero count means "no previous sample" and loads 1
  always_comb begin
    rep_cnt_nxt_s = rep_cnt_r;
    if (rep_cnt_r == REP_ZERO) begin
      rep_cnt_nxt_s = REP_ONE;
    end else if (sample_bit == prev_bit_r) begin
      if (rep_cnt_r == REP_MAX) begin
        rep_cnt_nxt_s = REP_MAX;
      end else begin
        rep_cnt_nxt_s = rep_cnt_r + REP_ONE;
      end
    end else begin
      rep_cnt_nxt_s = REP_ONE;
    end
    rep_hit_s = sample_en && (rep_cnt_nxt_s == REP_MAX) && (rep_cnt_r != REP_MAX);
  end

  // Adaptive proportion: window index 0 latches the reference bit
  always_comb begin
    ref_bit_nxt_s   = ref_bit_r;
    match_cnt_nxt_s = match_cnt_r;
    if (win_idx_r == IDX_ZERO) begin
      ref_bit_nxt_s   = sample_bit;
      match_cnt_nxt_s = MATCH_ONE;
    end else if (sample_bit == ref_bit_r) begin
      if (match_cnt_r == MATCH_MAX) begin
        match_cnt_nxt_s = MATCH_MAX;
      end else begin
        match_cnt_nxt_s = match_cnt_r + MATCH_ONE;
      end
    end else begin
      match_cnt_nxt_s = match_cnt_r;
    end
    apt_hit_s = sample_en && (match_cnt_nxt_s == MATCH_MAX) && (match_cnt_r != MATCH_MAX);
  end

  // Counter state: cleared while idle or on a clear request, else advanced per sample
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_r   <= REP_ZERO;
      prev_bit_r  <= 1'b0;
      win_idx_r   <= IDX_ZERO;
      ref_bit_r   <= 1'b0;
      match_cnt_r <= MATCH_ZERO;
    end else if (clear_fail || !sample_en) begin
      rep_cnt_r   <= REP_ZERO;
      prev_bit_r  <= prev_bit_r;
      win_idx_r   <= IDX_ZERO;
      ref_bit_r   <= ref_bit_r;
      match_cnt_r <= MATCH_ZERO;
    end else begin
      rep_cnt_r   <= rep_cnt_nxt_s;
      prev_bit_r  <= sample_bit;
      win_idx_r   <= win_idx_r + IDX_ONE;
      ref_bit_r   <= ref_bit_nxt_s;
      match_cnt_r <= match_cnt_nxt_s;
    end
  end

  // Sticky failure flags; a fresh detection outranks the clear request
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_fail_r <= 1'b0;
      apt_fail_r <= 1'b0;
    end else begin
      if (rep_hit_s) begin
        rep_fail_r <= 1'b1;
      end else if (clear_fail) begin
        rep_fail_r <= 1'b0;
      end else begin
        rep_fail_r <= rep_fail_r;
      end
      if (apt_hit_s) begin
        apt_fail_r <= 1'b1;
      end else if (clear_fail) begin
        apt_fail_r <= 1'b0;
      end else begin
        apt_fail_r <= apt_fail_r;
      end
    end
  end

  assign rep_fail = rep_fail_r;
  assign apt_fail = apt_fail_r;

endmodule

// File: rtl/entropy_conditioner.sv
// Entropy conditioner: synchronises the asynchronous raw bit, runs the health
// monitor on it and removes bias with a von Neumann extractor. Strobes are
// suppressed while any sticky failure flag is set.
// Optional macro ENTROPY_STARTUP_TEST_EN adds a startup test that must pass
// STARTUP_SAMPLES clean samples before the first strobe; without it
// o_startupDone is tied high.
module entropy_conditioner import entropy_pkg::*; #(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int REP_CUTOFF      = REP_CUTOFF_DEF,
  parameter int APT_WINDOW      = APT_WINDOW_DEF,
  parameter int APT_CUTOFF      = APT_CUTOFF_DEF,
  parameter int STARTUP_SAMPLES = STARTUP_SAMPLES_DEF
) (
  input  logic i_clock,
  input  logic i_rst,
  input  logic i_enb,
  input  logic i_rawBit,
  input  logic i_clearFail,
  output logic o_ranBit,
  output logic o_ranValid,
  output logic o_repFail,
  output logic o_aptFail,
  output logic o_startupDone
);

  if ((SYNC_STAGES < 2) || (STARTUP_SAMPLES < 1) || (APT_WINDOW < 2) ||
      ((APT_WINDOW & (APT_WINDOW - 1)) != 0)) begin : g_param_check
    $error("entropy_conditioner: illegal parameter set");
  end

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_bit_s;
  pair_state_e            state_r;
  pair_state_e            state_nxt_s;
  logic                   first_r;
  logic                   first_nxt_s;
  logic                   pair_done_s;
  logic                   pair_bit_s;
  logic                   emit_s;
  logic                   ran_bit_r;
  logic                   ran_valid_r;
  logic                   rep_fail_s;
  logic                   apt_fail_s;
  logic                   startup_done_s;

  // Raw-bit synchroniser chain, free-running regardless of the enable
  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], i_rawBit};
    end
  end

  assign sync_bit_s = sync_r[SYNC_STAGES-1];

  health_monitor #(
    .REP_CUTOFF (REP_CUTOFF),
    .APT_WINDOW (APT_WINDOW),
    .APT_CUTOFF (APT_CUTOFF)
  ) u_health (
    .clk        (i_clock),
    .rst        (i_rst),
    .sample_bit (sync_bit_s),
    .sample_en  (i_enb),
    .clear_fail (i_clearFail),
    .rep_fail   (rep_fail_s),
    .apt_fail   (apt_fail_s)
  );

`ifdef ENTROPY_STARTUP_TEST_EN
  localparam int SU_W = cnt_width(STARTUP_SAMPLES);
  localparam logic [SU_W-1:0] SU_ZERO = SU_W'(0);
  localparam logic [SU_W-1:0] SU_ONE  = SU_W'(1);
  localparam logic [SU_W-1:0] SU_LAST = SU_W'(STARTUP_SAMPLES - 1);

  logic [SU_W-1:0] su_cnt_r;
  logic            startup_done_r;

  // Startup test: count clean enabled samples, restart while a failure is flagged
  always_ff @(posedge i_clock) begin
    if (i_rst || !i_enb) begin
      su_cnt_r       <= SU_ZERO;
      startup_done_r <= 1'b0;
    end else if (rep_fail_s || apt_fail_s) begin
      su_cnt_r       <= SU_ZERO;
      startup_done_r <= startup_done_r;
    end else if (!startup_done_r) begin
      su_cnt_r       <= su_cnt_r + SU_ONE;
      startup_done_r <= (su_cnt_r == SU_LAST);
    end else begin
      su_cnt_r       <= su_cnt_r;
      startup_done_r <= startup_done_r;
    end
  end

  assign startup_done_s = startup_done_r;
`else
  assign startup_done_s = 1'b1;
`endif

  // Von Neumann pair tracker: next state and the pair result
  always_comb begin
    state_nxt_s = state_r;
    first_nxt_s = first_r;
    pair_done_s = 1'b0;
    pair_bit_s  = first_r;
    if (!i_enb) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          state_nxt_s = HALF;
          first_nxt_s = sync_bit_s;
        end
        HALF: begin
          state_nxt_s = EMPTY;
          if (first_r != sync_bit_s) begin
            pair_done_s = 1'b1;
            pair_bit_s  = first_r;
          end else begin
            pair_done_s = 1'b0;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
        end
      endcase
    end
    emit_s = pair_done_s && !rep_fail_s && !apt_fail_s && startup_done_s;
  end

  // Pair tracker state register
  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      state_r <= EMPTY;
      first_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      first_r <= first_nxt_s;
    end
  end

  // Registered output strobe; the bit only changes when a strobe is emitted
  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      ran_bit_r   <= 1'b0;
      ran_valid_r <= 1'b0;
    end else begin
      ran_valid_r <= emit_s;
      if (emit_s) begin
        ran_bit_r <= pair_bit_s;
      end else begin
        ran_bit_r <= ran_bit_r;
      end
    end
  end

  assign o_ranBit      = ran_bit_r;
  assign o_ranValid    = ran_valid_r;
  assign o_repFail     = rep_fail_s;
  assign o_aptFail     = apt_fail_s;
  assign o_startupDone = startup_done_s;

endmodule
